// File: rtl/regfile_pkg.sv
// Shared constants and request type for the register-file writeback arbiter.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry writeback hold. Accepted writes to r0 complete but are never stored.
module wb_hold_slot #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              drain,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [ADDR_W-1:0] out_reg,
  output logic [DATA_W-1:0] out_data
);
  import regfile_pkg::*;

  logic              valid_reg;
  logic [ADDR_W-1:0] reg_reg;
  logic [DATA_W-1:0] data_reg;
  logic              load;

  assign load = accept && (in_reg != ADDR_W'(REG_ZERO));

  // A refill on the same edge as a drain takes precedence, keeping one write per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      reg_reg   <= '0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      reg_reg   <= in_reg;
      data_reg  <= in_data;
    end else if (drain) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid    = valid_reg;
  assign out_reg  = reg_reg;
  assign out_data = data_reg;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto the single register-file write port.
// Define WB_ARB_RR_EN for round-robin on different-register conflicts instead of A priority + starvation guard.
module regfile_wb_arbiter #(
  parameter int DATA_W       = regfile_pkg::DATA_W,
  parameter int ADDR_W       = regfile_pkg::ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              o_wen,
  output logic [ADDR_W-1:0] o_wreg,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_pending
);
  import regfile_pkg::*;

  logic              a_held, b_held;
  logic [ADDR_W-1:0] a_hreg, b_hreg;
  logic [DATA_W-1:0] a_hdata, b_hdata;
  logic              grant_a, grant_b;
  logic              a_acc, b_acc, a_new, b_new, a_keep, b_keep;
  logic              b_older_reg, b_older_next;
  logic              wen_reg;
  logic [ADDR_W-1:0] wreg_reg;
  logic [DATA_W-1:0] wdata_reg;

`ifdef WB_ARB_RR_EN
  logic last_b_reg;
`else
  logic [3:0] starve_cnt_reg;
`endif

  assign a_ready = !a_held || grant_a;
  assign b_ready = !b_held || grant_b;
  assign a_acc   = a_valid && a_ready;
  assign b_acc   = b_valid && b_ready;
  assign a_new   = a_acc && (a_reg != ADDR_W'(REG_ZERO));
  assign b_new   = b_acc && (b_reg != ADDR_W'(REG_ZERO));
  assign a_keep  = a_held && !grant_a;
  assign b_keep  = b_held && !grant_b;

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_hold_a (
    .clk      (clk),
    .rst      (rst),
    .accept   (a_acc),
    .drain    (grant_a),
    .in_reg   (a_reg),
    .in_data  (a_data),
    .valid    (a_held),
    .out_reg  (a_hreg),
    .out_data (a_hdata)
  );

  wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_hold_b (
    .clk      (clk),
    .rst      (rst),
    .accept   (b_acc),
    .drain    (grant_b),
    .in_reg   (b_reg),
    .in_data  (b_data),
    .valid    (b_held),
    .out_reg  (b_hreg),
    .out_data (b_hdata)
  );

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_held && b_held) begin
      // Same destination: oldest first so the younger value is the one that sticks.
      if (a_hreg == b_hreg) begin
        if (b_older_reg) grant_b = 1'b1;
        else             grant_a = 1'b1;
      end else begin
`ifdef WB_ARB_RR_EN
        if (last_b_reg) grant_a = 1'b1;
        else            grant_b = 1'b1;
`else
        if (starve_cnt_reg == 4'(STARVE_LIMIT)) grant_b = 1'b1;
        else                                    grant_a = 1'b1;
`endif
      end
    end else begin
      grant_a = a_held;
      grant_b = b_held;
    end
  end

  // Age only matters while both holds end up occupied; an entry that stays put is older than a new one.
  always_comb begin
    b_older_next = b_older_reg;
    if (b_keep && a_new)      b_older_next = 1'b1;
    else if (a_keep && b_new) b_older_next = 1'b0;
    else if (a_new && b_new)  b_older_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_older_reg <= 1'b0;
      wen_reg     <= 1'b0;
      wreg_reg    <= '0;
      wdata_reg   <= '0;
    end else begin
      b_older_reg <= b_older_next;
      wen_reg     <= grant_a || grant_b;
      if (grant_a) begin
        wreg_reg  <= a_hreg;
        wdata_reg <= a_hdata;
      end else if (grant_b) begin
        wreg_reg  <= b_hreg;
        wdata_reg <= b_hdata;
      end
    end
  end

`ifdef WB_ARB_RR_EN
  // Reset to "B won last" so A takes the first contested cycle.
  always_ff @(posedge clk) begin
    if (rst)          last_b_reg <= 1'b1;
    else if (grant_a) last_b_reg <= 1'b0;
    else if (grant_b) last_b_reg <= 1'b1;
  end
`else
  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt_reg <= '0;
    else if (b_held && !grant_b)
      starve_cnt_reg <= (starve_cnt_reg == 4'(STARVE_LIMIT)) ? starve_cnt_reg : starve_cnt_reg + 4'd1;
    else
      starve_cnt_reg <= '0;
  end
`endif

  assign o_wen     = wen_reg;
  assign o_wreg    = wreg_reg;
  assign o_wdata   = wdata_reg;
  assign o_pending = a_held || b_held || wen_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        o_wen;
  logic [4:0]  o_wreg;
  logic [31:0] o_wdata;
  logic        o_pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_reg     (a_reg),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_reg     (b_reg),
    .b_data    (b_data),
    .o_wen     (o_wen),
    .o_wreg    (o_wreg),
    .o_wdata   (o_wdata),
    .o_pending (o_pending)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
    repeat (3) step();
    rst = 1'b0;
    n_cmp++; if (o_wen !== 1'b0)     begin n_bad++; $display("FAIL reset_wen got %b want 0", o_wen); end
    n_cmp++; if (o_wreg !== 5'd0)    begin n_bad++; $display("FAIL reset_wreg got %0d want 0", o_wreg); end
    n_cmp++; if (o_wdata !== 32'd0)  begin n_bad++; $display("FAIL reset_wdata got %h want 0", o_wdata); end
    n_cmp++; if (o_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending got %b want 0", o_pending); end
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1)
      begin n_bad++; $display("FAIL reset_ready got a=%b b=%b want 1/1", a_ready, b_ready); end
    $display("reset: wen=%b pending=%b a_ready=%b b_ready=%b", o_wen, o_pending, a_ready, b_ready);
  endtask

  task automatic test_single_a();
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h1234;
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready got %b want 1", a_ready); end
    step();
    a_valid = 1'b0;
    n_cmp++; if (o_wen !== 1'b0 || o_pending !== 1'b1)
      begin n_bad++; $display("FAIL single_lat1 got wen=%b pend=%b want 0/1", o_wen, o_pending); end
    step();
    n_cmp++; if (o_wen !== 1'b1 || o_wreg !== 5'd3 || o_wdata !== 32'h1234)
      begin n_bad++; $display("FAIL single_write got wen=%b r%0d=%h want 1 r3=00001234", o_wen, o_wreg, o_wdata); end
    step();
    n_cmp++; if (o_wen !== 1'b0 || o_pending !== 1'b0)
      begin n_bad++; $display("FAIL single_idle got wen=%b pend=%b want 0/0", o_wen, o_pending); end
    $display("single_a: r%0d=%h", o_wreg, o_wdata);
  endtask

  task automatic test_r0();
    b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hFFFF_FFFF;
    n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL r0_ready got %b want 1", b_ready); end
    step();
    b_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (o_wen !== 1'b0 || o_pending !== 1'b0)
        begin n_bad++; $display("FAIL r0_nowrite cycle %0d got wen=%b pend=%b want 0/0", i, o_wen, o_pending); end
      step();
    end
    $display("r0: wen=%b pending=%b", o_wen, o_pending);
  endtask

  task automatic test_same_reg();
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hA;
    b_valid = 1'b1; b_reg = 5'd5; b_data = 32'hB;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0)
      begin n_bad++; $display("FAIL same_ready got a=%b b=%b want 1/0", a_ready, b_ready); end
    step();
    n_cmp++; if (o_wen !== 1'b1 || o_wreg !== 5'd5 || o_wdata !== 32'hA)
      begin n_bad++; $display("FAIL same_first got wen=%b r%0d=%h want 1 r5=0000000a", o_wen, o_wreg, o_wdata); end
    step();
    n_cmp++; if (o_wen !== 1'b1 || o_wreg !== 5'd5 || o_wdata !== 32'hB)
      begin n_bad++; $display("FAIL same_second got wen=%b r%0d=%h want 1 r5=0000000b", o_wen, o_wreg, o_wdata); end
    step();
    n_cmp++; if (o_wen !== 1'b0) begin n_bad++; $display("FAIL same_idle got wen=%b want 0", o_wen); end
    $display("same_reg: last r%0d=%h", o_wreg, o_wdata);
  endtask

  // A streams to r1 while B waits on r2; B must win on its 5th contended cycle.
  task automatic test_starve();
    logic [31:0] exp_data [6];
    logic [4:0]  exp_reg  [6];
    logic        exp_rdy  [7];
    int          n_acc;
    logic        rdy_seen;
    exp_data = '{32'h100, 32'h101, 32'h102, 32'h103, 32'hB2, 32'h104};
    exp_reg  = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd2, 5'd1};
    exp_rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    n_acc = 0;
    a_valid = 1'b1; a_reg = 5'd1;
    b_valid = 1'b1; b_reg = 5'd2; b_data = 32'hB2;
    for (int c = 0; c < 7; c++) begin
      a_data = 32'h100 + 32'(n_acc);
      rdy_seen = a_ready;
      n_cmp++; if (a_ready !== exp_rdy[c])
        begin n_bad++; $display("FAIL starve_ready cycle %0d got %b want %b", c, a_ready, exp_rdy[c]); end
      step();
      b_valid = 1'b0;
      if (rdy_seen) n_acc++;
      if (c >= 1) begin
        n_cmp++; if (o_wen !== 1'b1 || o_wreg !== exp_reg[c-1] || o_wdata !== exp_data[c-1])
          begin n_bad++; $display("FAIL starve_write edge %0d got wen=%b r%0d=%h want 1 r%0d=%h",
                                  c, o_wen, o_wreg, o_wdata, exp_reg[c-1], exp_data[c-1]); end
        $display("starve: edge %0d write r%0d=%h", c, o_wreg, o_wdata);
      end
    end
    a_valid = 1'b0;
    step();
    n_cmp++; if (o_wen !== 1'b1 || o_wdata !== 32'h105)
      begin n_bad++; $display("FAIL starve_tail got wen=%b data=%h want 1 00000105", o_wen, o_wdata); end
    repeat (2) step();
    n_cmp++; if (o_pending !== 1'b0) begin n_bad++; $display("FAIL starve_drain got pend=%b want 0", o_pending); end
  endtask

  task automatic test_back_to_back();
    a_valid = 1'b1; a_reg = 5'd7;
    for (int i = 0; i < 5; i++) begin
      a_data = 32'h200 + 32'(i);
      n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready cycle %0d got %b want 1", i, a_ready); end
      step();
      if (i >= 1) begin
        n_cmp++; if (o_wen !== 1'b1 || o_wreg !== 5'd7 || o_wdata !== 32'h200 + 32'(i - 1))
          begin n_bad++; $display("FAIL b2b_write %0d got wen=%b r%0d=%h want 1 r7=%h", i, o_wen, o_wreg, o_wdata, 32'h200 + 32'(i - 1)); end
        $display("b2b: write r%0d=%h", o_wreg, o_wdata);
      end
    end
    a_valid = 1'b0;
    step();
    n_cmp++; if (o_wen !== 1'b1 || o_wdata !== 32'h204)
      begin n_bad++; $display("FAIL b2b_last got wen=%b data=%h want 1 00000204", o_wen, o_wdata); end
    step();
    n_cmp++; if (o_wen !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got wen=%b want 0", o_wen); end
  endtask

  task automatic test_reset_mid();
    a_valid = 1'b1; a_reg = 5'd8; a_data = 32'hAA;
    b_valid = 1'b1; b_reg = 5'd9; b_data = 32'hBB;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_full got b_ready=%b want 0", b_ready); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (o_wen !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b1 || o_pending !== 1'b0)
      begin n_bad++; $display("FAIL rstmid_after got wen=%b a_rdy=%b b_rdy=%b pend=%b want 0/1/1/0",
                              o_wen, a_ready, b_ready, o_pending); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (o_wen !== 1'b0) begin n_bad++; $display("FAIL rstmid_nowrite cycle %0d got wen=%b data=%h want 0", i, o_wen, o_wdata); end
    end
    $display("reset_mid: wen=%b pending=%b", o_wen, o_pending);
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_r0();
    test_same_reg();
`ifndef WB_ARB_RR_EN
    test_starve();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
